// File: rtl/add_accum_pkg.sv
// add_accum_pkg: shared state encoding, item width and default sizing for the add_accum frame accumulator.
package add_accum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int ITEM_W    = 5;
    localparam int ACC_W_DEF = 8;
    localparam int CNT_W_DEF = 4;

endpackage

// File: rtl/add_accum_dp.sv
// add_accum_dp: ACC_W-bit add of a 5-bit item with carry-out detection.
// Defining ADD_ACCUM_SAT_EN clamps the result at all-ones instead of wrapping.
module add_accum_dp
    import add_accum_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0]  acc_i,
    input  logic [ITEM_W-1:0] item_i,
    output logic [ACC_W-1:0]  sum_o,
    output logic              carry_o
);

    logic [ACC_W:0] full;

    always_comb begin
        full    = {1'b0, acc_i} + (ACC_W+1)'(item_i);
        carry_o = full[ACC_W];
`ifdef ADD_ACCUM_SAT_EN
        sum_o   = carry_o ? {ACC_W{1'b1}} : full[ACC_W-1:0];
`else
        sum_o   = full[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/add_accum.sv
// add_accum: collects {cout,sum} items into framed totals with overflow flag and saturating item count.
// Valid/ready on both sides; the result is held in DONE until the downstream handshake.
module add_accum
    import add_accum_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_sum,
    input  logic             in_cout,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_count
);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d, dp_sum;
    logic               ovf_q, ovf_d, dp_carry;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               accept, hs;

    add_accum_dp #(.ACC_W(ACC_W)) u_dp (
        .acc_i   (acc_q),
        .item_i  ({in_cout, in_sum}),
        .sum_o   (dp_sum),
        .carry_o (dp_carry)
    );

    always_comb begin
        in_ready  = (state_q != DONE);
        out_valid = (state_q == DONE);
        accept    = in_valid && in_ready;
        hs        = out_valid && out_ready;
        state_d   = state_q;
        if (accept)
            state_d = in_last ? DONE : ACCUM;
        else if (hs)
            state_d = IDLE;
        // Emptying DONE returns the datapath to zero so IDLE always starts a fresh frame.
        acc_d     = hs ? '0 : accept ? dp_sum : acc_q;
        ovf_d     = hs ? 1'b0 : accept ? (ovf_q | dp_carry) : ovf_q;
        cnt_d     = hs ? '0 : (accept && cnt_q != {CNT_W{1'b1}}) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_acc   = acc_q;
    assign out_ovf   = ovf_q;
    assign out_count = cnt_q;

endmodule
